// File: rtl/wave_capture_if.sv
// -----------------------------------------------------------------------------
// wave_capture_if
//   Bundles the sample stream, display status and ping-pong RAM write port
//   that connect wave_capture to its environment.
//
//   Signals
//     new_sample_ready   one-cycle strobe, new_sample_in valid this cycle
//     new_sample_in      signed two's-complement audio sample (SAMPLE_W bits)
//     wave_display_idle  display is outside its active waveform region
//     write_address      RAM write address {~read_index, count[7:0]}
//     write_enable       RAM write strobe, one cycle per captured sample
//     write_sample       offset-binary 8-bit sample
//     read_index         RAM half currently owned by the display
//
//   Modports
//     master  environment side: drives the stream and idle, sees the RAM port
//     slave   wave_capture side
// -----------------------------------------------------------------------------
interface wave_capture_if #(
   parameter int SAMPLE_W = 16
);
   logic                new_sample_ready;
   logic [SAMPLE_W-1:0] new_sample_in;
   logic                wave_display_idle;
   logic [8:0]          write_address;
   logic                write_enable;
   logic [7:0]          write_sample;
   logic                read_index;

   modport master (
      output new_sample_ready,
      output new_sample_in,
      output wave_display_idle,
      input  write_address,
      input  write_enable,
      input  write_sample,
      input  read_index
   );

   modport slave (
      input  new_sample_ready,
      input  new_sample_in,
      input  wave_display_idle,
      output write_address,
      output write_enable,
      output write_sample,
      output read_index
   );
endinterface

// File: rtl/wave_capture.sv
// -----------------------------------------------------------------------------
// wave_capture
//   Upstream feeder for wave_display. Waits for a rising zero crossing of the
//   audio stream, then writes one 256-sample frame into the half of a 512x8
//   ping-pong RAM that the display is not reading. Once the frame is complete
//   and the display reports idle, read_index toggles so the halves swap.
//
//   Ports
//     clk    system clock, rising edge
//     reset  synchronous, active-high
//     bus    wave_capture_if.slave (sample stream, display idle, RAM write
//            port, read_index); every output is registered
//
//   Parameters
//     SAMPLE_W    width of the signed input sample (>= 8)
//     DECIM_LOG2  log2 of the capture decimation ratio; present only in the
//                 decimating build
//
//   Build option
//     WAVE_CAPTURE_DECIM_EN  when defined, only every 2^DECIM_LOG2-th strobe
//                            after the trigger is written, so a frame spans
//                            256*2^DECIM_LOG2 input samples. Undefined (the
//                            default) writes every strobe and has no phase
//                            counter.
// -----------------------------------------------------------------------------
module wave_capture #(
   parameter int SAMPLE_W   = 16
`ifdef WAVE_CAPTURE_DECIM_EN
   ,
   parameter int DECIM_LOG2 = 1
`endif
) (
   input  logic           clk,
   input  logic           reset,
   wave_capture_if.slave  bus
);

   typedef enum logic [1:0] {
      S_ARMED  = 2'd0,
      S_ACTIVE = 2'd1,
      S_WAIT   = 2'd2
   } state_t;

   state_t     state_r;
   logic [7:0] count_r;
   logic       read_index_r;
   logic       write_enable_r;
   logic [8:0] write_address_r;
   logic [7:0] write_sample_r;
   logic       prev_msb_r;

   logic       sample_msb_s;
   logic [7:0] sample_code_s;
   logic       trigger_s;
   logic       take_s;

`ifdef WAVE_CAPTURE_DECIM_EN
   // Phase of the *next* strobe within the decimation period; the trigger
   // sample itself occupies phase 0.
   logic [DECIM_LOG2-1:0] phase_r;
`endif

   // Sample decode: sign bit, offset-binary top byte and zero-crossing trigger.
   always_comb begin
      sample_msb_s  = bus.new_sample_in[SAMPLE_W-1];
      // Flipping the sign bit turns two's complement into offset binary.
      sample_code_s = {~bus.new_sample_in[SAMPLE_W-1],
                       bus.new_sample_in[SAMPLE_W-2 -: 7]};
      // Previous negative, current non-negative (zero counts as non-negative).
      trigger_s     = bus.new_sample_ready & prev_msb_r & ~sample_msb_s;
   end

   // Decimation gate: decides whether an ACTIVE strobe is written.
   always_comb begin
`ifdef WAVE_CAPTURE_DECIM_EN
      if (phase_r == {DECIM_LOG2{1'b0}}) begin
         take_s = 1'b1;
      end else begin
         take_s = 1'b0;
      end
`else
      take_s = 1'b1;
`endif
   end

   // Capture FSM with registered RAM write port and read_index.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r         <= S_ARMED;
         count_r         <= 8'd0;
         read_index_r    <= 1'b0;
         write_enable_r  <= 1'b0;
         write_address_r <= 9'h100;
         write_sample_r  <= 8'h00;
         prev_msb_r      <= 1'b0;
`ifdef WAVE_CAPTURE_DECIM_EN
         phase_r         <= {DECIM_LOG2{1'b0}};
`endif
      end else begin
         write_enable_r <= 1'b0;

         // Sign history tracks every strobe regardless of state.
         if (bus.new_sample_ready) begin
            prev_msb_r <= sample_msb_s;
         end

         case (state_r)
            S_ARMED: begin
               if (trigger_s) begin
                  write_enable_r  <= 1'b1;
                  write_address_r <= {~read_index_r, 8'd0};
                  write_sample_r  <= sample_code_s;
                  count_r         <= 8'd1;
                  state_r         <= S_ACTIVE;
`ifdef WAVE_CAPTURE_DECIM_EN
                  phase_r         <= DECIM_LOG2'(1);
`endif
               end
            end

            S_ACTIVE: begin
               if (bus.new_sample_ready) begin
`ifdef WAVE_CAPTURE_DECIM_EN
                  phase_r <= phase_r + DECIM_LOG2'(1);
`endif
                  if (take_s) begin
                     write_enable_r  <= 1'b1;
                     write_address_r <= {~read_index_r, count_r};
                     write_sample_r  <= sample_code_s;
                     // 8-bit count wraps 255 -> 0 on the last write.
                     count_r         <= count_r + 8'd1;
                     if (count_r == 8'd255) begin
                        state_r <= S_WAIT;
                     end
                  end
               end
            end

            S_WAIT: begin
               // Swap halves only while the display is idle; a strobe in the
               // same cycle has already updated prev_msb above and nothing else.
               if (bus.wave_display_idle) begin
                  read_index_r <= ~read_index_r;
                  state_r      <= S_ARMED;
               end
            end

            default: begin
               state_r <= S_ARMED;
            end
         endcase
      end
   end

   assign bus.write_address = write_address_r;
   assign bus.write_enable  = write_enable_r;
   assign bus.write_sample  = write_sample_r;
   assign bus.read_index    = read_index_r;

endmodule

// File: tb/tb_wave_capture.sv
// -----------------------------------------------------------------------------
// tb_wave_capture
//   Directed bench for wave_capture. Each expected RAM write is queued when
//   the strobe that should cause it is driven, and popped when the cycle
//   after that strobe is sampled.
// -----------------------------------------------------------------------------
module tb_wave_capture;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   wave_capture_if #(.SAMPLE_W(16)) bus ();

   wave_capture #(
      .SAMPLE_W(16)
`ifdef WAVE_CAPTURE_DECIM_EN
      ,
      .DECIM_LOG2(1)
`endif
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [8:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t  exp_q[$];
   logic exp_ri;
   int   checks   = 0;
   int   failures = 0;

   function automatic logic [7:0] enc(input logic [15:0] v);
      return {~v[15], v[14:8]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
   task automatic cyc(input logic rst, input logic rdy, input logic [15:0] s, input logic idle);
      wr_t  w;
      logic exp_we;
      @(negedge clk);
      reset                 = rst;
      bus.new_sample_ready  = rdy;
      bus.new_sample_in     = s;
      bus.wave_display_idle = idle;
      @(posedge clk);
      #1;
      exp_we = (exp_q.size() != 0) ? 1'b1 : 1'b0;
      chk("write_enable", {31'd0, bus.write_enable}, {31'd0, exp_we});
      chk("read_index", {31'd0, bus.read_index}, {31'd0, exp_ri});
      if (exp_q.size() != 0) begin
         w = exp_q.pop_front();
         chk("write_address", {23'd0, bus.write_address}, {23'd0, w.addr});
         chk("write_sample", {24'd0, bus.write_sample}, {24'd0, w.data});
      end
   endtask

   // Strobe one sample; optionally expect it written at addr.
   task automatic strobe(input logic [15:0] s, input bit wr, input logic [8:0] addr);
      wr_t w;
      if (wr) begin
         w.addr = addr;
         w.data = enc(s);
         exp_q.push_back(w);
      end
      cyc(1'b0, 1'b1, s, 1'b0);
   endtask

   initial begin
      logic [15:0] v;
      reset                 = 1'b1;
      bus.new_sample_ready  = 1'b0;
      bus.new_sample_in     = 16'h0000;
      bus.wave_display_idle = 1'b0;
      exp_ri                = 1'b0;

      // Reset state
      cyc(1'b1, 1'b0, 16'h0000, 1'b0);
      cyc(1'b1, 1'b0, 16'h0000, 1'b0);
      chk("reset_address", {23'd0, bus.write_address}, 32'h0000_0100);
      chk("reset_sample", {24'd0, bus.write_sample}, 32'h0000_0000);

      // -5, -3, +2: only the rising crossing writes, at 0x100 with 0x80
      strobe(16'hFFFB, 1'b0, 9'h000);
      cyc(1'b0, 1'b0, 16'h8000, 1'b0);
      strobe(16'hFFFD, 1'b0, 9'h000);
      strobe(16'h0002, 1'b1, 9'h100);
      cyc(1'b0, 1'b0, 16'h0000, 1'b0);

      // Rest of the frame: full-scale positive, addresses 0x101..0x1FF
      for (int i = 1; i < 256; i++) begin
         strobe(16'h7FFF, 1'b1, {1'b1, 8'(i)});
      end

      // WAIT with display busy: crossings ignored, no swap
      for (int i = 0; i < 50; i++) begin
         strobe((i % 2 == 0) ? 16'hFFF0 : 16'h0010, 1'b0, 9'h000);
      end
      strobe(16'hFFFF, 1'b0, 9'h000);

      // Idle plus a would-be trigger sample in the same cycle: swap only
      exp_ri = 1'b1;
      cyc(1'b0, 1'b1, 16'h0005, 1'b1);
      strobe(16'h0003, 1'b0, 9'h000);
      // Idle while ARMED must not move read_index
      cyc(1'b0, 1'b0, 16'h0000, 1'b1);

      // Constant input never triggers
      for (int i = 0; i < 10000; i++) begin
         strobe(16'd100, 1'b0, 9'h000);
      end
      for (int i = 0; i < 10000; i++) begin
         strobe(16'hFF9C, 1'b0, 9'h000);
      end

      // -1 then 0 triggers; new frame lands in half 0
      strobe(16'hFFFF, 1'b0, 9'h000);
      strobe(16'h0000, 1'b1, 9'h000);
      for (int i = 1; i < 37; i++) begin
         v = 16'($urandom);
         strobe(v, 1'b1, {1'b0, 8'(i)});
      end

      // Reset at count 37 abandons the frame
      exp_ri = 1'b0;
      cyc(1'b1, 1'b1, 16'h1234, 1'b0);
      chk("midreset_address", {23'd0, bus.write_address}, 32'h0000_0100);
      chk("midreset_sample", {24'd0, bus.write_sample}, 32'h0000_0000);

      // Retrigger restarts at 0x100
      strobe(16'h8000, 1'b0, 9'h000);
      strobe(16'h7FFF, 1'b1, 9'h100);
`ifdef WAVE_CAPTURE_DECIM_EN
      for (int i = 1; i < 512; i++) begin
         v = 16'($urandom);
         strobe(v, (i % 2 == 0), {1'b1, 8'(i / 2)});
      end
`else
      for (int i = 1; i < 256; i++) begin
         v = 16'($urandom);
         strobe(v, 1'b1, {1'b1, 8'(i)});
      end
`endif

      // Frame complete: crossings ignored until idle
      for (int i = 0; i < 6; i++) begin
         strobe((i % 2 == 0) ? 16'h8001 : 16'h0001, 1'b0, 9'h000);
      end
      exp_ri = 1'b1;
      cyc(1'b0, 1'b0, 16'h0000, 1'b1);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
